// File: rtl/oled_panel_ctrl.sv
// SSD1306-class OLED controller: power-up/init sequencing, 4-wire SPI byte engine and page-wise
// character-frame refresh from a snapshot of char_data. Define OLED_PWRDN_EN to add pwr_off/OFF.
module oled_panel_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int ROWS     = 4,
   parameter int COLS     = 16,
   parameter int DLY_VDD  = 100000,
   parameter int DLY_RES  = 1000,
   parameter int DLY_VBAT = 10000000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   cs,
   output logic                   sdo,
   output logic                   sclk,
   output logic                   dc,
   output logic                   res,
   output logic                   vbat,
   output logic                   vdd,
   input  logic [ROWS*COLS*8-1:0] char_data,
   input  logic                   refresh_req,
   input  logic                   cont,
   output logic [7:0]             font_char,
   output logic [2:0]             font_col,
   input  logic [7:0]             font_byte,
`ifdef OLED_PWRDN_EN
   input  logic                   pwr_off,
`endif
   output logic                   busy,
   output logic                   print_fin
);

   localparam int DLY_MAX = (DLY_VDD > DLY_RES) ? ((DLY_VDD > DLY_VBAT) ? DLY_VDD : DLY_VBAT)
                                                : ((DLY_RES > DLY_VBAT) ? DLY_RES : DLY_VBAT);
   localparam int CW    = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int NDATA = COLS * 8;
   localparam int BW    = $clog2(NDATA + 4);
   localparam int PW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int HW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int NCH   = ROWS * COLS;
   localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef OLED_PWRDN_EN
   typedef enum logic [3:0] {S_IDLE, S_PWR, S_CMD_OFF, S_RES_LO, S_RES_HI, S_INIT, S_VBAT,
                             S_CFG, S_READY, S_FRAME, S_PD_CMD, S_PD_WAIT, S_OFF} state_t;
`else
   typedef enum logic [3:0] {S_IDLE, S_PWR, S_CMD_OFF, S_RES_LO, S_RES_HI, S_INIT, S_VBAT,
                             S_CFG, S_READY, S_FRAME} state_t;
`endif

   // Command list: [0] display off, [1..4] charge pump/precharge, [5..11] panel config + on
   function automatic logic [7:0] init_byte(input logic [3:0] i);
      case (i)
         4'd0:    init_byte = 8'hAE;
         4'd1:    init_byte = 8'h8D;
         4'd2:    init_byte = 8'h14;
         4'd3:    init_byte = 8'hD9;
         4'd4:    init_byte = 8'hF1;
         4'd5:    init_byte = 8'h81;
         4'd6:    init_byte = 8'h0F;
         4'd7:    init_byte = 8'hA1;
         4'd8:    init_byte = 8'hC8;
         4'd9:    init_byte = 8'hDA;
         4'd10:   init_byte = 8'h20;
         default: init_byte = 8'hAF;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      idx_q, idx_d;
   logic            busy_q, busy_d, vdd_q, vdd_d, vbat_q, vbat_d, res_q, res_d;
   logic            pend_q, pend_d, print_fin_q, print_fin_d;
   logic [PW-1:0]   page_q, page_d;
   logic [BW-1:0]   bidx_q, bidx_d;
   logic [HW-1:0]   chr_q, chr_d;
   logic [2:0]      col_q, col_d;
   logic [7:0]      font_char_q, font_char_d;
   logic [2:0]      font_col_q, font_col_d;
   logic [7:0]      snap_q [NCH];
   logic [7:0]      snap_d [NCH];
   logic [IW-1:0]   cidx;
   logic            go, go_dc, start_frame;
   logic [7:0]      go_byte;

   logic            spi_busy_q, spi_busy_d, gap_q, gap_d;
   logic            cs_q, cs_d, sclk_q, sclk_d, sdo_q, sdo_d, dc_q, dc_d;
   logic [7:0]      sh_q, sh_d;
   logic [2:0]      bit_q, bit_d;
   logic [DW-1:0]   div_q, div_d;

   assign cidx = IW'(int'(page_q) * COLS + int'(chr_q));

   always_comb begin
      state_d = state_q;   cnt_d = cnt_q;     idx_d = idx_q;
      busy_d = busy_q;     vdd_d = vdd_q;     vbat_d = vbat_q;   res_d = res_q;
      pend_d = pend_q;     print_fin_d = 1'b0;
      page_d = page_q;     bidx_d = bidx_q;   chr_d = chr_q;     col_d = col_q;
      font_char_d = font_char_q;              font_col_d = font_col_q;
      snap_d = snap_q;
      go = 1'b0;           go_byte = 8'h00;   go_dc = 1'b0;      start_frame = 1'b0;
      if (refresh_req && busy_q) pend_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            state_d = S_PWR; busy_d = 1'b1; vdd_d = 1'b0; cnt_d = CW'(DLY_VDD - 1);
         end
         S_PWR:
            if (cnt_q == '0) begin state_d = S_CMD_OFF; idx_d = 4'd0; end
            else cnt_d = cnt_q - 1'b1;
         S_CMD_OFF:
            if (!spi_busy_q) begin
               if (idx_q == 4'd1) begin state_d = S_RES_LO; res_d = 1'b0; cnt_d = CW'(DLY_RES - 1); end
               else begin go = 1'b1; go_byte = init_byte(idx_q); idx_d = idx_q + 4'd1; end
            end
         S_RES_LO:
            if (cnt_q == '0) begin state_d = S_RES_HI; res_d = 1'b1; cnt_d = CW'(DLY_RES - 1); end
            else cnt_d = cnt_q - 1'b1;
         S_RES_HI:
            if (cnt_q == '0) state_d = S_INIT;
            else cnt_d = cnt_q - 1'b1;
         S_INIT:
            if (!spi_busy_q) begin
               if (idx_q == 4'd5) begin state_d = S_VBAT; vbat_d = 1'b0; cnt_d = CW'(DLY_VBAT - 1); end
               else begin go = 1'b1; go_byte = init_byte(idx_q); idx_d = idx_q + 4'd1; end
            end
         S_VBAT:
            if (cnt_q == '0) state_d = S_CFG;
            else cnt_d = cnt_q - 1'b1;
         S_CFG:
            if (!spi_busy_q) begin
               if (idx_q == 4'd12) begin state_d = S_READY; busy_d = 1'b0; end
               else begin go = 1'b1; go_byte = init_byte(idx_q); idx_d = idx_q + 4'd1; end
            end
         S_READY: begin
`ifdef OLED_PWRDN_EN
            if (pwr_off) begin state_d = S_PD_CMD; idx_d = 4'd0; busy_d = 1'b1; end else
`endif
            if (refresh_req || pend_q || cont) start_frame = 1'b1;
         end
         S_FRAME:
            if (!spi_busy_q) begin
               // Page header: set page, column low nibble 0, column high nibble 0
               if (bidx_q < BW'(3)) begin
                  go = 1'b1;
                  go_byte = (bidx_q == BW'(0)) ? (8'hB0 + 8'(page_q)) :
                            (bidx_q == BW'(1)) ? 8'h00 : 8'h10;
                  bidx_d = bidx_q + 1'b1;
               end else if (bidx_q != BW'(NDATA + 3)) begin
                  go = 1'b1; go_dc = 1'b1; go_byte = font_byte; bidx_d = bidx_q + 1'b1;
                  if (col_q == 3'd7) begin
                     col_d = 3'd0;
                     chr_d = (chr_q == HW'(COLS - 1)) ? '0 : chr_q + 1'b1;
                  end else col_d = col_q + 3'd1;
               end else if (page_q != PW'(ROWS - 1)) begin
                  page_d = page_q + 1'b1; bidx_d = '0;
               end else begin
                  print_fin_d = 1'b1;
`ifdef OLED_PWRDN_EN
                  if (pwr_off) begin state_d = S_PD_CMD; idx_d = 4'd0; end else
`endif
                  if (cont || pend_q) start_frame = 1'b1;
                  else begin state_d = S_READY; busy_d = 1'b0; end
               end
            end
`ifdef OLED_PWRDN_EN
         S_PD_CMD:
            if (!spi_busy_q) begin
               if (idx_q == 4'd1) begin state_d = S_PD_WAIT; vbat_d = 1'b1; cnt_d = CW'(DLY_VBAT - 1); end
               else begin go = 1'b1; go_byte = init_byte(idx_q); idx_d = idx_q + 4'd1; end
            end
         S_PD_WAIT:
            if (cnt_q == '0) begin state_d = S_OFF; vdd_d = 1'b1; end
            else cnt_d = cnt_q - 1'b1;
         S_OFF: ;
`endif
         default: ;
      endcase
      if (start_frame) begin
         state_d = S_FRAME; busy_d = 1'b1; pend_d = 1'b0;
         page_d = '0; bidx_d = '0; chr_d = '0; col_d = 3'd0;
         for (int i = 0; i < NCH; i++) snap_d[i] = char_data[8*i +: 8];
      end
      // Font address trails the counters by one clk so it stays put across each byte load
      if (state_q == S_FRAME) begin
         font_char_d = snap_q[cidx];
         font_col_d  = col_q;
      end
   end

   always_comb begin
      cs_d = cs_q;   sclk_d = sclk_q;   sdo_d = sdo_q;   dc_d = dc_q;
      sh_d = sh_q;   bit_d = bit_q;     div_d = div_q;
      spi_busy_d = spi_busy_q;          gap_d = gap_q;
      if (go) begin
         cs_d = 1'b0; sclk_d = 1'b0; sdo_d = go_byte[7]; dc_d = go_dc;
         sh_d = {go_byte[6:0], 1'b0}; bit_d = 3'd0; div_d = DW'(CLK_DIV - 1); spi_busy_d = 1'b1;
      end else if (gap_q) begin
         gap_d = 1'b0; spi_busy_d = 1'b0;
      end else if (spi_busy_q) begin
         if (div_q != '0) div_d = div_q - 1'b1;
         else begin
            div_d = DW'(CLK_DIV - 1);
            if (!sclk_q) sclk_d = 1'b1;
            else if (bit_q == 3'd7) begin cs_d = 1'b1; gap_d = 1'b1; end
            else begin
               sclk_d = 1'b0; sdo_d = sh_q[7]; sh_d = {sh_q[6:0], 1'b0}; bit_d = bit_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;  cnt_q <= '0;      idx_q <= 4'd0;
         busy_q <= 1'b0;     vdd_q <= 1'b1;    vbat_q <= 1'b1;    res_q <= 1'b1;
         pend_q <= 1'b0;     print_fin_q <= 1'b0;
         page_q <= '0;       bidx_q <= '0;     chr_q <= '0;       col_q <= 3'd0;
         font_char_q <= 8'h00;                 font_col_q <= 3'd0;
         spi_busy_q <= 1'b0; gap_q <= 1'b0;    bit_q <= 3'd0;     div_q <= '0;
         cs_q <= 1'b1;       sclk_q <= 1'b1;   sdo_q <= 1'b0;     dc_q <= 1'b0;
      end else begin
         state_q <= state_d; cnt_q <= cnt_d;   idx_q <= idx_d;
         busy_q <= busy_d;   vdd_q <= vdd_d;   vbat_q <= vbat_d;  res_q <= res_d;
         pend_q <= pend_d;   print_fin_q <= print_fin_d;
         page_q <= page_d;   bidx_q <= bidx_d; chr_q <= chr_d;    col_q <= col_d;
         font_char_q <= font_char_d;           font_col_q <= font_col_d;
         spi_busy_q <= spi_busy_d; gap_q <= gap_d; bit_q <= bit_d; div_q <= div_d;
         cs_q <= cs_d;       sclk_q <= sclk_d; sdo_q <= sdo_d;    dc_q <= dc_d;
      end
   end

   always_ff @(posedge clk) begin
      sh_q   <= sh_d;
      snap_q <= snap_d;
   end

   assign cs = cs_q;     assign sclk = sclk_q;   assign sdo = sdo_q;   assign dc = dc_q;
   assign res = res_q;   assign vdd = vdd_q;     assign vbat = vbat_q;
   assign busy = busy_q; assign print_fin = print_fin_q;
   assign font_char = font_char_q;               assign font_col = font_col_q;

endmodule

// File: tb/tb_oled_panel_ctrl.sv
// Directed bench for oled_panel_ctrl: SPI byte monitor feeding a scoreboard of expected {dc,byte}.
module tb_oled_panel_ctrl;
   localparam int CLK_DIV = 2;
   localparam int ROWS    = 1;
   localparam int COLS    = 2;
   localparam int DLY     = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs, sdo, sclk, dc, res, vbat, vdd, busy, print_fin;
   logic [15:0] char_data = 16'h4241;
   logic        refresh_req = 1'b0;
   logic        cont = 1'b0;
   logic [7:0]  font_char;
   logic [2:0]  font_col;
   logic [7:0]  font_byte = 8'h00;
`ifdef OLED_PWRDN_EN
   logic        pwr_off = 1'b0;
`endif

   oled_panel_ctrl #(
      .CLK_DIV(CLK_DIV), .ROWS(ROWS), .COLS(COLS),
      .DLY_VDD(DLY), .DLY_RES(DLY), .DLY_VBAT(DLY)
   ) dut (
      .clk(clk), .rst(rst), .cs(cs), .sdo(sdo), .sclk(sclk), .dc(dc), .res(res),
      .vbat(vbat), .vdd(vdd), .char_data(char_data), .refresh_req(refresh_req),
      .cont(cont), .font_char(font_char), .font_col(font_col), .font_byte(font_byte),
`ifdef OLED_PWRDN_EN
      .pwr_off(pwr_off),
`endif
      .busy(busy), .print_fin(print_fin)
   );

   always #5 clk = ~clk;

   // Font ROM model with one clock of latency
   always @(posedge clk) font_byte <= font_char ^ {5'b0, font_col};

   int          checks = 0;
   int          errors = 0;
   logic [8:0]  exp_q[$];
   int          mon_bytes = 0;
   int          nbits = 0;
   int          lowcnt = 0;
   int          fin_cnt = 0;
   logic [7:0]  mon_sh = 8'h00;
   logic [8:0]  got;
   logic [7:0]  init_list [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                   8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_init();
      for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_list[i]});
   endtask

   task automatic push_frame(input logic [15:0] cd);
      exp_q.push_back({1'b0, 8'hB0});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h10});
      for (int c = 0; c < COLS; c++)
         for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, cd[8*c +: 8] ^ 8'(k)});
   endtask

   task automatic pulse_refresh();
      refresh_req = 1'b1;
      tick(1);
      refresh_req = 1'b0;
   endtask

   task automatic wait_fin(input string tag, input int target);
      int n = 0;
      while (fin_cnt < target && n < 3000) begin tick(1); n++; end
      chk(tag, n < 3000, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 3000) begin tick(1); n++; end
      chk(tag, n < 3000, 1);
   endtask

   task automatic run_frame(input string tag, input logic [15:0] cd);
      int base = fin_cnt;
      char_data = cd;
      push_frame(cd);
      pulse_refresh();
      wait_fin({tag, "_fin_timeout"}, base + 1);
      wait_idle({tag, "_idle_timeout"});
      tick(20);
      chk({tag, "_fin_pulses"}, fin_cnt - base, 1);
      chk({tag, "_all_bytes"}, exp_q.size(), 0);
      chk({tag, "_busy_low"}, busy, 0);
   endtask

   always @(posedge sclk) if (cs === 1'b0 && !rst) begin
      mon_sh = {mon_sh[6:0], sdo};
      nbits++;
   end

   always @(posedge clk) if (cs === 1'b0) lowcnt++;

   always @(posedge clk) if (print_fin === 1'b1) fin_cnt++;

   always @(posedge cs) begin
      if (rst) begin
         nbits  = 0;
         lowcnt = 0;
      end else begin
         chk("spi_bit_count", nbits, 8);
         chk("cs_low_clk", lowcnt, 16 * CLK_DIV);
         chk("sclk_idle_high", sclk, 1);
         chk("byte_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("spi_dc_byte", {dc, mon_sh}, got);
         end
         mon_bytes++;
         nbits  = 0;
         lowcnt = 0;
      end
   end

   initial begin
      int n;
      int base;
      tick(3);
      chk("reset_outputs", {cs, sclk, sdo, dc, res, vdd, vbat, busy, print_fin, font_char, font_col},
          {9'b1_1_0_0_1_1_1_0_0, 8'h00, 3'h0});

      // Power-up and init command list
      push_init();
      @(negedge clk) rst = 1'b0;
      tick(1);
      chk("vdd_on_clk1", vdd, 0);
      chk("busy_powerup", busy, 1);
      n = 0;
      while (res !== 1'b0 && n < 1000) begin tick(1); n++; end
      chk("res_fall_timeout", n < 1000, 1);
      n = 0;
      while (res === 1'b0 && n < 1000) begin tick(1); n++; end
      chk("res_low_clk", n, DLY);
      n = 0;
      while (vbat !== 1'b0 && n < 2000) begin tick(1); n++; end
      chk("vbat_fall_timeout", n < 2000, 1);
      chk("vbat_after_5_cmds", mon_bytes, 5);
      wait_idle("init_idle_timeout");
      chk("init_byte_count", mon_bytes, 12);
      chk("init_all_bytes", exp_q.size(), 0);

      // Single frames
      run_frame("frame_4241", 16'h4241);
      run_frame("frame_a5a5", 16'hA5A5);

      // Continuous refresh with a mid-frame data change
      base = fin_cnt;
      char_data = 16'h4241;
      push_frame(16'h4241);
      cont = 1'b1;
      tick(300);
      char_data = 16'h5A5A;
      push_frame(16'h5A5A);
      wait_fin("cont_fin1_timeout", base + 1);
      tick(100);
      cont = 1'b0;
      wait_fin("cont_fin2_timeout", base + 2);
      wait_idle("cont_idle_timeout");
      tick(100);
      chk("cont_fin_pulses", fin_cnt - base, 2);
      chk("cont_all_bytes", exp_q.size(), 0);
      chk("cont_busy_low", busy, 0);

      // Reset in the middle of a data byte
      exp_q.push_back({1'b0, 8'hB0});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h10});
      pulse_refresh();
      n = 0;
      while (!(dc === 1'b1 && cs === 1'b0) && n < 500) begin tick(1); n++; end
      chk("data_byte_timeout", n < 500, 1);
      tick(3);
      #2 rst = 1'b1;
      #1;
      chk("reset_mid_byte", {cs, sclk, sdo, dc, res, vdd, vbat, busy, print_fin, font_char, font_col},
          {9'b1_1_0_0_1_1_1_0_0, 8'h00, 3'h0});
      chk("hdr_bytes_before_reset", exp_q.size(), 0);
      exp_q.delete();
      tick(3);

      // Re-init with refresh requests collapsing into one pending frame
      char_data = 16'h3130;
      push_init();
      base = fin_cnt;
      @(negedge clk) rst = 1'b0;
      tick(20);
      push_frame(16'h3130);
      pulse_refresh();
      tick(40);
      pulse_refresh();
      tick(140);
      pulse_refresh();
      wait_fin("pend_fin_timeout", base + 1);
      wait_idle("pend_idle_timeout");
      tick(200);
      chk("pend_fin_pulses", fin_cnt - base, 1);
      chk("pend_all_bytes", exp_q.size(), 0);
      chk("pend_busy_low", busy, 0);
      chk("supplies_stay_on", {vdd, vbat}, 0);

`ifdef OLED_PWRDN_EN
      // Power-down from READY
      base = fin_cnt;
      exp_q.push_back({1'b0, 8'hAE});
      pwr_off = 1'b1;
      n = 0;
      while (vbat !== 1'b1 && n < 500) begin tick(1); n++; end
      chk("pd_vbat_timeout", n < 500, 1);
      pwr_off = 1'b0;
      n = 0;
      while (vdd !== 1'b1 && n < 100) begin tick(1); n++; end
      chk("pd_vdd_delay", n, DLY);
      pulse_refresh();
      tick(100);
      chk("pd_refresh_ignored", fin_cnt - base, 0);
      chk("pd_busy_high", busy, 1);
      chk("pd_all_bytes", exp_q.size(), 0);
      chk("pd_cs_idle", cs, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
